// File: rtl/jc_phase_monitor.sv
// Johnson-code phase monitor: validates each sampled Johnson word, decodes it to a
// binary phase, tracks single-step advance and reports lock, wrap and error events.
module jc_phase_monitor #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              jc_in,
  input  logic                          in_valid,
  input  logic                          clr_err,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic                          phase_valid,
  output logic                          locked,
  output logic                          wrap,
  output logic                          illegal,
  output logic                          seq_err,
  output logic [ERR_W-1:0]              err_count
);

  localparam int unsigned PW  = $clog2(2*WIDTH);
  localparam int unsigned NPH = 2*WIDTH;
  localparam int unsigned GW  = 8;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ref;
  logic [GW-1:0]     r_good;
  logic [PW-1:0]     r_phase;
  logic              r_phase_valid;
  logic              r_wrap;
  logic              r_illegal;
  logic              r_seq_err;
  logic [ERR_W-1:0]  r_err_count;

  logic [WIDTH-1:0]  w_inv;
  logic [PW-1:0]     w_ones;
  logic              w_lsb_run;
  logic              w_msb_run;
  logic              w_legal;
  logic [PW-1:0]     w_dec_phase;
  logic [PW-1:0]     w_succ;
  logic              w_is_succ;
  logic              w_event;
  logic              w_err_sat;

  // A legal word is either a low-aligned run of ones or the complement of one.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_ones = w_ones + PW'(jc_in[i]);
    end
    w_inv       = ~jc_in;
    w_lsb_run   = ((jc_in & (jc_in + WIDTH'(1))) == '0);
    w_msb_run   = ((w_inv & (w_inv + WIDTH'(1))) == '0) && (jc_in != '0);
    w_legal     = w_lsb_run || w_msb_run;
    w_dec_phase = w_lsb_run ? w_ones : (PW'(WIDTH) + PW'(WIDTH) - w_ones);
  end

  always_comb begin
    w_succ    = (r_ref == PW'(NPH - 1)) ? '0 : (r_ref + PW'(1));
    w_is_succ = (w_dec_phase == w_succ);
    w_event   = in_valid && (!w_legal || ((r_state != ST_UNLOCKED) && !w_is_succ));
    w_err_sat = (r_err_count == {ERR_W{1'b1}});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_UNLOCKED;
      r_ref         <= '0;
      r_good        <= '0;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_wrap        <= 1'b0;
      r_illegal     <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
      r_seq_err <= 1'b0;
      if (in_valid) begin
        if (!w_legal) begin
          r_illegal     <= 1'b1;
          r_phase_valid <= 1'b0;
          r_good        <= '0;
          r_state       <= ST_UNLOCKED;
        end else begin
          r_phase       <= w_dec_phase;
          r_phase_valid <= 1'b1;
          r_ref         <= w_dec_phase;
          case (r_state)
            ST_UNLOCKED: begin
              r_good  <= '0;
              r_state <= ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
              if (w_is_succ) begin
                r_good <= r_good + GW'(1);
                if ((r_good + GW'(1)) == GW'(LOCK_CNT)) begin
                  r_state <= ST_LOCKED;
                end
              end else begin
                r_seq_err <= 1'b1;
                r_good    <= '0;
              end
            end
            ST_LOCKED: begin
              if (w_is_succ) begin
                r_wrap <= (r_ref == PW'(NPH - 1));
              end else begin
                r_seq_err <= 1'b1;
                r_good    <= '0;
                r_state   <= ST_ACQUIRE;
              end
            end
            default: begin
              r_good  <= '0;
              r_state <= ST_UNLOCKED;
            end
          endcase
        end
      end
    end
  end

  // Clear takes priority over a coincident error event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (clr_err) begin
      r_err_count <= '0;
    end else if (w_event && !w_err_sat) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign phase       = r_phase;
  assign phase_valid = r_phase_valid;
  assign locked      = (r_state == ST_LOCKED);
  assign wrap        = r_wrap;
  assign illegal     = r_illegal;
  assign seq_err     = r_seq_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_jc_phase_monitor.sv
// Scoreboard bench for jc_phase_monitor: stimulus pushes expected outputs, a
// monitor pops and compares one cycle after each driven cycle.
module tb_jc_phase_monitor;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NPH      = 32;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned ERR_W    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  jc_in;
  logic              in_valid;
  logic              clr_err;
  logic [4:0]        phase;
  logic              phase_valid;
  logic              locked;
  logic              wrap;
  logic              illegal;
  logic              seq_err;
  logic [ERR_W-1:0]  err_count;

  jc_phase_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .jc_in(jc_in), .in_valid(in_valid), .clr_err(clr_err),
    .phase(phase), .phase_valid(phase_valid), .locked(locked), .wrap(wrap),
    .illegal(illegal), .seq_err(seq_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] phase;
    logic       pv;
    logic       locked;
    logic       wrap;
    logic       illegal;
    logic       seq_err;
    logic [7:0] err;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (0 unlocked, 1 acquire, 2 locked)
  int m_state, m_ref, m_good, m_phase, m_err;
  bit m_pv;

  function automatic logic [15:0] code_of(input int p);
    logic [15:0] c;
    if (p <= 16) begin
      c = 16'h0000;
      for (int i = 0; i < p; i++) c[i] = 1'b1;
    end else begin
      c = 16'hFFFF;
      for (int i = 0; i < p - 16; i++) c[i] = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [15:0] jc_next(input logic [15:0] x);
    return {x[14:0], ~x[15]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_ref = 0; m_good = 0; m_phase = 0; m_err = 0; m_pv = 0;
  endtask

  task automatic model_step(input logic [15:0] w, input logic v, input logic clr);
    exp_t e;
    int   p;
    bit   found;
    e = '0;
    if (v) begin
      found = 0; p = 0;
      for (int k = 0; k < int'(NPH); k++) if (code_of(k) == w) begin found = 1; p = k; end
      if (!found) begin
        e.illegal = 1; m_pv = 0; m_state = 0; m_good = 0;
      end else begin
        m_phase = p; m_pv = 1;
        if (m_state == 0) begin
          m_good = 0; m_state = 1;
        end else if (p == (m_ref + 1) % int'(NPH)) begin
          if (m_state == 1) begin
            m_good++;
            if (m_good == int'(LOCK_CNT)) m_state = 2;
          end else begin
            e.wrap = (m_ref == int'(NPH) - 1);
          end
        end else begin
          e.seq_err = 1; m_good = 0; m_state = 1;
        end
        m_ref = p;
      end
    end
    if (clr) m_err = 0;
    else if ((e.illegal || e.seq_err) && m_err < 255) m_err++;
    e.phase = 5'(m_phase); e.pv = m_pv; e.locked = (m_state == 2); e.err = 8'(m_err);
    q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] w, input logic v, input logic clr);
    @(negedge clk);
    jc_in = w; in_valid = v; clr_err = clr;
    model_step(w, v, clr);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  // Monitor: every driven cycle yields one output cycle to compare.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {phase, phase_valid, locked, wrap, illegal, seq_err, err_count};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got ph=%0d pv=%0b lk=%0b wr=%0b il=%0b se=%0b ec=%0d expected ph=%0d pv=%0b lk=%0b wr=%0b il=%0b se=%0b ec=%0d",
                   $time, a.phase, a.pv, a.locked, a.wrap, a.illegal, a.seq_err, a.err,
                   e.phase, e.pv, e.locked, e.wrap, e.illegal, e.seq_err, e.err);
        end
      end
    end
  end

  initial begin
    logic [15:0] jc;
    int p;
    reset = 1'b0; jc_in = '0; in_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", {phase, phase_valid, locked, wrap, illegal, seq_err, err_count}, 0);
    @(negedge clk); reset = 1'b1;

    // Free-running Johnson counter from 0x0000
    jc = 16'h0000;
    for (int i = 0; i < 80; i++) begin
      drive(jc, 1'b1, 1'b0);
      if (i == 3) begin settle(); check("not_locked_phase3", locked, 0); end
      if (i == 4) begin settle(); check("locked_at_phase4", locked, 1); check("phase4", phase, 4); end
      if (i == 31) begin settle(); check("phase31", phase, 31); check("no_wrap_31", wrap, 0); end
      if (i == 32 || i == 64) begin settle(); check("wrap_pulse", wrap, 1); check("wrap_phase0", phase, 0); end
      jc = jc_next(jc);
    end
    settle(); check("freerun_err0", err_count, 0);

    // Glitch while locked (phase 16 slot replaced)
    drive(16'h0005, 1'b1, 1'b0);
    settle();
    check("glitch_illegal", illegal, 1); check("glitch_unlock", locked, 0); check("glitch_err1", err_count, 1);
    for (p = 17; p <= 21; p++) begin
      drive(code_of(p), 1'b1, 1'b0);
      if (p == 20) begin settle(); check("relock_not_yet", locked, 0); end
    end
    settle(); check("relock_after5", locked, 1);

    // Skip from phase 10 to phase 12, then a repeated phase
    for (p = 22; p < 32 + 11; p++) drive(code_of(p % 32), 1'b1, 1'b0);
    drive(code_of(12), 1'b1, 1'b0);
    settle(); check("skip_seq_err", seq_err, 1); check("skip_unlock", locked, 0); check("skip_phase12", phase, 12);
    for (p = 13; p <= 16; p++) begin
      drive(code_of(p), 1'b1, 1'b0);
      if (p == 15) begin settle(); check("skip_not_locked", locked, 0); end
    end
    settle(); check("skip_relock", locked, 1);
    drive(code_of(16), 1'b1, 1'b0);
    settle(); check("repeat_seq_err", seq_err, 1); check("repeat_unlock", locked, 0);
    for (p = 17; p <= 21; p++) drive(code_of(p), 1'b1, 1'b0);

    // Decode spot checks, with idle gaps between samples
    drive(16'hFFFF, 1'b1, 1'b0); settle(); check("dec_ffff", phase, 16);
    drive(16'h1234, 1'b0, 1'b0);
    drive(16'h00FF, 1'b1, 1'b0); settle(); check("dec_00ff", phase, 8);
    drive(16'hFFF0, 1'b1, 1'b0); settle(); check("dec_fff0", phase, 20);
    drive(16'h0101, 1'b1, 1'b0); settle();
    check("dec_0101_illegal", illegal, 1); check("dec_0101_pv", phase_valid, 0);

    // Relock then stall 20 cycles
    for (p = 0; p <= 6; p++) drive(code_of(p), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(16'($urandom), 1'b0, 1'b0);
    settle(); check("stall_locked_hold", locked, 1); check("stall_phase_hold", phase, 6);

    // Saturation and clear-wins
    for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 16'h0101 : 16'h0005, 1'b1, 1'b0);
    settle(); check("err_saturated", err_count, 255);
    drive(16'h0005, 1'b1, 1'b1); settle(); check("clr_wins", err_count, 0);
    drive(16'h0000, 1'b0, 1'b0); settle(); check("clr_stays", err_count, 0);

    // Asynchronous reset mid-lock
    for (p = 0; p <= 6; p++) drive(code_of(p), 1'b1, 1'b0);
    drive(code_of(7), 1'b0, 1'b0);
    @(posedge clk); #3;
    check("prereset_locked", locked, 1);
    reset = 1'b0;
    #1;
    check("async_reset_clear", {phase, phase_valid, locked, wrap, illegal, seq_err, err_count}, 0);
    model_reset();
    @(negedge clk); reset = 1'b1;
    for (p = 7; p <= 11; p++) begin
      drive(code_of(p), 1'b1, 1'b0);
      if (p == 10) begin settle(); check("postreset_not_locked", locked, 0); end
    end
    settle(); check("postreset_relock", locked, 1);

    drive(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jc_phase_monitor.md
# jc_phase_monitor

Downstream consumer of the 16-bit Johnson counter. It samples the counter's parallel output and checks each sample is a legal Johnson code. It decodes each legal sample to a binary phase index and tracks that successive samples advance by exactly one phase. It raises lock, wrap and error indications, and keeps a saturating error count for the rest of the design.

## Interface
- `WIDTH`, 16: Johnson register width N; there are 2N phases.
- `LOCK_CNT`, 4: consecutive correct successor samples needed to declare lock (1..255).
- `ERR_W`, 8: error counter width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `jc_in` input WIDTH: Johnson counter output word.
- `in_valid` input 1: `jc_in` is sampled on a rising edge of `clk` only while this is high.
- `clr_err` input 1: synchronous clear of `err_count`.
- `phase` output clog2(2N): binary phase of the last legal sample.
- `phase_valid` output 1: `phase` holds a decoded legal sample.
- `locked` output 1: high while the FSM is in LOCKED.
- `wrap` output 1: one-cycle pulse on a locked step from phase 2N-1 to phase 0.
- `illegal` output 1: one-cycle pulse; the sample was not a legal Johnson code.
- `seq_err` output 1: one-cycle pulse; the sample was legal but was not the successor of the reference phase.
- `err_count` output ERR_W: count of `illegal` plus `seq_err` events, saturating.

## Operation
- Legal codes and their phase:
  - All-zero word: phase 0.
  - LSB-aligned run of k ones (bits [k-1:0] set, rest clear), k = 1..N: phase k. All-ones is phase N.
  - MSB-aligned run of ones with j trailing zeros, j = 1..N-1: phase N+j. For N=16, 0xFFFE is phase 17 and 0x8000 is phase 31.
  - Any other pattern is illegal.
- Successor rule: the new phase must equal (ref+1) mod 2N. A repeated phase is a `seq_err`.
- FSM states: UNLOCKED, ACQUIRE, LOCKED. A register `ref` holds the reference phase; a counter `good` counts correct successors.
- UNLOCKED:
  - Legal sample: `ref` = phase, `good` = 0, go to ACQUIRE.
  - Illegal sample: pulse `illegal`, stay.
  - No `seq_err` is possible in this state.
- ACQUIRE:
  - Successor: `ref` advances and `good` increments. When `good` reaches LOCK_CNT, go to LOCKED.
  - Legal non-successor: pulse `seq_err`, `ref` = new phase, `good` = 0, stay in ACQUIRE.
  - Illegal sample: pulse `illegal`, go to UNLOCKED.
- LOCKED:
  - Successor: stay. Pulse `wrap` if ref was 2N-1.
  - Legal non-successor: pulse `seq_err`, `ref` = new phase, `good` = 0, go to ACQUIRE.
  - Illegal sample: pulse `illegal`, go to UNLOCKED.
- `phase` and `phase_valid`:
  - Updated on every legal sampled word.
  - An illegal sample leaves `phase` unchanged and clears `phase_valid`.
- `err_count`:
  - Increments by 1 per `illegal` or `seq_err` event.
  - Saturates at 2^ERR_W-1.
  - If `clr_err` coincides with an event, the clear wins and the count is 0.
- `in_valid` low: no state change; all pulse outputs are 0.

## Timing
- Reset (asserted `reset`=0, asynchronous): `phase`=0, `phase_valid`=0, `locked`=0, `wrap`=0, `illegal`=0, `seq_err`=0, `err_count`=0. FSM goes to UNLOCKED, `ref`=0, `good`=0.
- Deassertion of reset is taken on the next rising edge of `clk`.
- Latency is 1 cycle. All outputs are registered and reflect the word sampled on the previous edge where `in_valid`=1.
- `locked` rises on the same edge that updates `phase` for the LOCK_CNT-th good successor.
- `locked` falls on the same edge that flags the breaking sample.
- Pulses last exactly one cycle per event, even for back-to-back events.
- Reset asserted mid-lock clears everything immediately. Re-lock needs 1 + LOCK_CNT legal samples.
- A 16-bit Johnson counter running freely with `in_valid`=1 is locked 5 cycles after its first sample, and wraps every 32 cycles after that.

## Test plan
- Free-running lock: drive `jc_in` from a running 16-bit Johnson counter starting at 0x0000.
  - `phase` follows 0,1,2,…
  - `locked`=1 on the output cycle showing phase 4.
  - `wrap` pulses when phase 31 (0x8000) is followed by phase 0, then every 32 cycles.
  - `err_count` stays 0.
- Decode spot checks: single samples 0xFFFF, 0x00FF and 0xFFF0.
  - Phases are 16, 8 and 20 respectively.
  - 0x0101 gives `illegal`=1 and `phase_valid`=0.
- Glitch while locked: replace one sample with 0x0005.
  - `illegal` pulses, `locked` drops, `err_count`=1.
  - Re-lock occurs after 5 further legal in-sequence samples.
- Skip while locked: jump from phase 10 to phase 12.
  - `seq_err` pulses and the FSM goes to ACQUIRE with `ref`=12.
  - Lock returns after phases 13..16.
  - A repeated phase is also a `seq_err`.
- Stall and saturation:
  - With `in_valid`=0 for 20 cycles, all outputs hold and there are no pulses.
  - Feed 300 illegal words with ERR_W=8: `err_count` saturates at 255.
  - `clr_err` together with an error gives 0.
- Async reset mid-run: pull `reset` low between clock edges while locked.
  - All outputs clear immediately, before the next clock edge.
